// File: rtl/cdc_hs_rx.sv
// ---------------------------------------------------------------------------
// cdc_hs_rx
// Receives a 4-phase req/ack transfer in the syn_clk domain. The source holds
// data_in stable while req is high. req arrives here already synchronized as
// req_s. This block captures data_in once and presents it on a valid/ready
// interface. It acknowledges the source after the downstream consumer takes
// the word. The ack line is synchronized back to the source outside this block.
//
// Ports:
//   syn_clk     destination-domain clock
//   rst         asynchronous reset, active-high
//   req_s       synchronized request from the source
//   data_in     [K-1:0] source data, stable while req is high (not synchronized)
//   out_ready   downstream consumer ready
//   out_data    [K-1:0] captured data (registered)
//   out_valid   out_data valid (registered)
//   ack         acknowledge to the source (direct flop output)
//   xfer_count  [CW-1:0] completed transfers, wraps modulo 2^CW
//   proto_err   sticky flag: source dropped req before being acknowledged
// ---------------------------------------------------------------------------
module cdc_hs_rx #(
    parameter int K   = 8,
    parameter int CW  = 16,
    parameter int GAP = 2
) (
    input  logic          syn_clk,
    input  logic          rst,
    input  logic          req_s,
    input  logic [K-1:0]  data_in,
    input  logic          out_ready,
    output logic [K-1:0]  out_data,
    output logic          out_valid,
    output logic          ack,
    output logic [CW-1:0] xfer_count,
    output logic          proto_err
);

    // The gap counter only has to hold GAP, so it needs at least one bit.
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_ACK     = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic [K-1:0]    out_data_q,  out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            ack_q,       ack_d;
    logic [CW-1:0]   count_q,     count_d;
    logic            err_q,       err_d;
    logic [GW-1:0]   gap_q,       gap_d;

    always_ff @(posedge syn_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            count_q     <= count_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = ack_q;
        count_d     = count_q;
        err_d       = err_q;
        gap_d       = gap_q;

        case (state_q)
            S_IDLE: begin
                // The only edge on which the unsynchronized bus is sampled.
                // req_s being high guarantees that data_in has settled.
                if (req_s) begin
                    out_data_d  = data_in;
                    out_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end
            end

            S_PRESENT: begin
                // A withdrawn request makes the word untrustworthy. This check
                // wins even if the consumer is ready on the same edge.
                if (!req_s) begin
                    err_d       = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    count_d     = count_q + CW'(1);
                    state_d     = S_ACK;
                end
            end

            S_ACK: begin
                if (!req_s) begin
                    ack_d = 1'b0;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GW'(GAP);
                        state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                // req_s is ignored here on purpose. A new request waits until
                // IDLE, which gives the source time to change data_in.
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                if (gap_q <= GW'(1)) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign ack        = ack_q;
    assign xfer_count = count_q;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// ---------------------------------------------------------------------------
// tb_cdc_hs_rx
// Randomized, scoreboard-checked bench for cdc_hs_rx.
// A driver process plays the 4-phase source and the consumer. It pushes each
// word it expects to be delivered into exp_q. A monitor process pops exp_q
// whenever the DUT completes a valid/ready handshake. The monitor also tracks
// the expected transfer count (modulo 2^CW) and checks ack and xfer_count on
// the following edge.
// ---------------------------------------------------------------------------
module tb_cdc_hs_rx;

    localparam int TB_K   = 8;
    localparam int TB_CW  = 2;
    localparam int TB_GAP = 2;

    logic                syn_clk = 1'b0;
    logic                rst     = 1'b1;
    logic                req_s   = 1'b0;
    logic [TB_K-1:0]     data_in = '0;
    logic                out_ready = 1'b0;
    logic [TB_K-1:0]     out_data;
    logic                out_valid;
    logic                ack;
    logic [TB_CW-1:0]    xfer_count;
    logic                proto_err;

    cdc_hs_rx #(.K(TB_K), .CW(TB_CW), .GAP(TB_GAP)) dut (
        .syn_clk    (syn_clk),
        .rst        (rst),
        .req_s      (req_s),
        .data_in    (data_in),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .ack        (ack),
        .xfer_count (xfer_count),
        .proto_err  (proto_err)
    );

    always #5 syn_clk = ~syn_clk;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    // Reference model state
    logic [TB_K-1:0] exp_q[$];
    int              mdl_count = 0;
    logic            mdl_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the active edge. Driver-side checks are
    // made at that same point.
    task automatic tick();
        @(posedge syn_clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Wait for ack, then drop req. ack must fall on the next edge.
    task automatic complete();
        int i;
        i = 0;
        while (!ack && i < 20) begin
            tick();
            i++;
        end
        chk("ack_timeout", {31'd0, ack}, 32'd1);
        chk("valid_after_ack", {31'd0, out_valid}, 32'd0);
        req_s     = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        tick();
        chk("ack_fall", {31'd0, ack}, 32'd0);
        chk("proto_err_sticky", {31'd0, proto_err}, {31'd0, mdl_err});
    endtask

    // Normal transfer: the consumer stalls for ready_delay cycles after capture.
    task automatic xfer(input logic [TB_K-1:0] d, input int ready_delay, output int lat);
        exp_q.push_back(d);
        data_in   = d;
        req_s     = 1'b1;
        out_ready = (ready_delay == 0);
        wait_valid(lat);
        for (int i = 0; i < ready_delay; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {24'd0, out_data}, {24'd0, d});
            chk("hold_no_ack", {31'd0, ack}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        complete();
        txn_no++;
        $display("txn %0d xfer data=%02h stall=%0d latency=%0d count=%0d err=%0b",
                 txn_no, d, ready_delay, lat, xfer_count, proto_err);
    endtask

    // The source raises req for `hold` cycles and withdraws it unacknowledged.
    task automatic withdraw(input logic [TB_K-1:0] d, input int hold);
        int n;
        data_in   = d;
        req_s     = 1'b1;
        out_ready = 1'b0;
        wait_valid(n);
        for (int i = 1; i < hold; i++) begin
            chk("wd_no_ack", {31'd0, ack}, 32'd0);
            chk("wd_data", {24'd0, out_data}, {24'd0, d});
            tick();
        end
        req_s = 1'b0;
        tick();
        mdl_err = 1'b1;
        chk("wd_proto_err", {31'd0, proto_err}, 32'd1);
        chk("wd_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("wd_no_ack_end", {31'd0, ack}, 32'd0);
        chk("wd_count_same", {30'd0, xfer_count}, mdl_count);
        txn_no++;
        $display("txn %0d withdraw data=%02h hold=%0d count=%0d err=%0b",
                 txn_no, d, hold, xfer_count, proto_err);
    endtask

    // Monitor and scoreboard
    initial begin : monitor
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge syn_clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("ack_rise", {31'd0, ack}, 32'd1);
                    chk("xfer_count", {30'd0, xfer_count}, mdl_count);
                    pend = 1'b0;
                end
                // A presented word with req held and a ready consumer is taken
                // on the next edge.
                if (out_valid && out_ready && req_s) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("sb_out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                    end
                    mdl_count = (mdl_count + 1) % (1 << TB_CW);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int lat;
        int n;
        logic [TB_CW-1:0] wrap_seq [5];
        wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
        wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_xfer_count", {30'd0, xfer_count}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic transfer: valid one edge after req is sampled
        xfer(8'hA5, 0, lat);
        chk("basic_latency", lat, 32'd1);

        // Backpressure
        xfer(8'h3C, 5, lat);

        // Early withdraw, then a normal transfer with the error still set
        withdraw(8'hC3, 2);
        xfer(8'h5E, 1, lat);

        // Gap: raise req in the first GAP cycle. Capture must wait for IDLE.
        exp_q.push_back(8'h11);
        data_in   = 8'hEE;
        req_s     = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
            if (n == 1) data_in = 8'h11;
        end
        chk("gap_latency", n, TB_GAP + 1);
        chk("gap_data", {24'd0, out_data}, 32'h11);
        complete();
        txn_no++;
        $display("txn %0d gap data=11 latency=%0d count=%0d", txn_no, n, xfer_count);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 2)
                withdraw(8'($urandom), $urandom_range(1, 3));
            else
                xfer(8'($urandom), $urandom_range(0, 4), lat);
        end

        // Async reset while ack is high
        exp_q.push_back(8'h77);
        data_in   = 8'h77;
        req_s     = 1'b1;
        out_ready = 1'b1;
        wait_valid(n);
        n = 0;
        while (!ack && n < 20) begin
            tick();
            n++;
        end
        chk("pre_rst_ack", {31'd0, ack}, 32'd1);
        @(negedge syn_clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ack", {31'd0, ack}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_count", {30'd0, xfer_count}, 32'd0);
        chk("arst_err", {31'd0, proto_err}, 32'd0);
        exp_q.delete();
        mdl_count = 0;
        mdl_err   = 1'b0;
        rst = 1'b0;
        exp_q.push_back(8'h77);
        tick();
        chk("post_rst_capture_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_capture_data", {24'd0, out_data}, 32'h77);
        complete();
        chk("wrap_count_0", {30'd0, xfer_count}, {30'd0, wrap_seq[0]});
        txn_no++;
        $display("txn %0d post-reset data=77 count=%0d", txn_no, xfer_count);

        // Wrap: four more transfers after the post-reset one
        for (int i = 1; i < 5; i++) begin
            xfer(8'(8'h20 + i), 0, lat);
            chk("wrap_count", {30'd0, xfer_count}, {30'd0, wrap_seq[i]});
        end

        repeat (4) tick();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
